// File: rtl/enc16x4_irq.sv
// Sticky 16-line interrupt encoder with a valid/ready output stage.
// Pending bits latch every request; the selected index is cleared when its code is accepted.
module enc16x4_irq #(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] mask,
  input  logic        ready,
  output logic        valid,
  output logic [3:0]  Y,
  output logic [15:0] pend,
  output logic [4:0]  pend_cnt
);

  logic        fire;
  logic        load;
  logic [15:0] ack_mask;
  logic [15:0] cand;

  function automatic logic [3:0] encode(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    if (HI_FIRST) begin
      for (int i = 0; i < 16; i++) if (v[i]) idx = 4'(i);
    end else begin
      for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign fire     = valid & ready;
  assign load     = ~valid | ready;
  assign ack_mask = fire ? (16'h0001 << Y) : 16'h0000;
  // The code being accepted this edge must not be re-selected from the same pend image.
  assign cand     = pend & ~ack_mask & ~mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= '0;
      valid <= 1'b0;
      Y     <= '0;
    end else begin
      pend <= (pend & ~ack_mask) | req;
      if (load) begin
        valid <= |cand;
        if (|cand) Y <= encode(cand);
      end
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < 16; i++) pend_cnt = pend_cnt + 5'(pend[i]);
  end

endmodule

// File: tb/tb_enc16x4_irq.sv
// Self-checking bench: HI_FIRST=1 and HI_FIRST=0 instances share stimulus;
// expected codes are queued per instance and popped on each accepted handshake.
module tb_enc16x4_irq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] mask;
  logic        ready;

  logic        valid_hi, valid_lo;
  logic [3:0]  y_hi, y_lo;
  logic [15:0] pend_hi, pend_lo;
  logic [4:0]  cnt_hi, cnt_lo;

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] q_hi[$];
  logic [3:0] q_lo[$];

  always #5 clk = ~clk;

  enc16x4_irq #(.HI_FIRST(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ready(ready),
    .valid(valid_hi), .Y(y_hi), .pend(pend_hi), .pend_cnt(cnt_hi)
  );

  enc16x4_irq #(.HI_FIRST(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ready(ready),
    .valid(valid_lo), .Y(y_lo), .pend(pend_lo), .pend_cnt(cnt_lo)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake seen before an edge must match the next queued code.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ready === 1'b1) begin
      if (valid_hi === 1'b1) begin
        if (q_hi.size() == 0) chk("hi_unexpected_code", 32'(y_hi), 32'hFFFF);
        else chk("hi_code", 32'(y_hi), 32'(q_hi.pop_front()));
      end
      if (valid_lo === 1'b1) begin
        if (q_lo.size() == 0) chk("lo_unexpected_code", 32'(y_lo), 32'hFFFF);
        else chk("lo_code", 32'(y_lo), 32'(q_lo.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; mask = '0; ready = 1'b1;
    #2;
    chk("rst_pend", 32'(pend_hi), 0);
    chk("rst_valid", 32'(valid_hi), 0);
    chk("rst_y", 32'(y_hi), 0);
    chk("rst_cnt", 32'(cnt_lo), 0);
    tick(); tick();
    #2 rst_n = 1'b1;

    // single request
    q_hi.push_back(4'h5); q_lo.push_back(4'h5);
    tick(); req = 16'h0020;
    tick(); req = '0;
    chk("single_pend_e1", 32'(pend_hi), 32'h0020);
    chk("single_valid_e1", 32'(valid_hi), 0);
    tick();
    chk("single_valid_e2", 32'(valid_hi), 1);
    chk("single_y_e2", 32'(y_hi), 5);
    tick();
    chk("single_pend_e3", 32'(pend_hi), 0);
    chk("single_valid_e3", 32'(valid_hi), 0);
    chk("single_y_hold", 32'(y_hi), 5);

    // priority with backpressure
    ready = 1'b0; req = 16'h8101;
    tick(); req = '0;
    chk("prio_pend", 32'(pend_hi), 32'h8101);
    chk("prio_cnt3", 32'(cnt_hi), 3);
    tick(); tick(); tick();
    chk("prio_hold_valid", 32'(valid_hi), 1);
    chk("prio_hold_y_hi", 32'(y_hi), 32'hF);
    chk("prio_hold_y_lo", 32'(y_lo), 0);
    q_hi.push_back(4'hF); q_hi.push_back(4'h8); q_hi.push_back(4'h0);
    q_lo.push_back(4'h0); q_lo.push_back(4'h8); q_lo.push_back(4'hF);
    ready = 1'b1;
    tick();
    chk("prio_cnt2_hi", 32'(cnt_hi), 2);
    chk("prio_y2_hi", 32'(y_hi), 8);
    chk("prio_cnt2_lo", 32'(cnt_lo), 2);
    tick();
    chk("prio_cnt1_hi", 32'(cnt_hi), 1);
    chk("prio_y3_lo", 32'(y_lo), 32'hF);
    tick();
    chk("prio_cnt0_hi", 32'(cnt_hi), 0);
    chk("prio_cnt0_lo", 32'(cnt_lo), 0);
    chk("prio_done_valid", 32'(valid_lo), 0);

    // mask
    mask = 16'h0001; req = 16'h0003;
    q_hi.push_back(4'h1); q_lo.push_back(4'h1);
    tick(); req = '0;
    tick();
    chk("mask_y", 32'(y_lo), 1);
    tick();
    chk("mask_pend_kept", 32'(pend_lo), 32'h0001);
    chk("mask_valid_off", 32'(valid_lo), 0);
    tick();
    chk("mask_still_off", 32'(valid_hi), 0);
    q_hi.push_back(4'h0); q_lo.push_back(4'h0);
    mask = '0;
    tick();
    chk("unmask_valid", 32'(valid_hi), 1);
    chk("unmask_y", 32'(y_hi), 0);
    tick();
    chk("unmask_pend", 32'(pend_hi), 0);

    // re-arm: request held through acceptance
    q_hi.push_back(4'h4); q_hi.push_back(4'h4);
    q_lo.push_back(4'h4); q_lo.push_back(4'h4);
    req = 16'h0010;
    tick(); tick();
    chk("rearm_y", 32'(y_hi), 4);
    tick(); req = '0;
    chk("rearm_pend", 32'(pend_hi), 32'h0010);
    chk("rearm_gap", 32'(valid_hi), 0);
    tick();
    chk("rearm_valid", 32'(valid_hi), 1);
    chk("rearm_y2", 32'(y_lo), 4);
    tick();
    chk("rearm_clear", 32'(pend_lo), 0);

    // higher-priority arrival does not disturb an outstanding code
    ready = 1'b0; req = 16'h0002;
    tick(); req = '0;
    tick();
    chk("late_y_first", 32'(y_hi), 1);
    req = 16'h0800;
    tick(); req = '0;
    tick();
    chk("late_y_stable", 32'(y_hi), 1);
    chk("late_pend", 32'(pend_hi), 32'h0802);
    q_hi.push_back(4'h1); q_hi.push_back(4'hB);
    q_lo.push_back(4'h1); q_lo.push_back(4'hB);
    ready = 1'b1;
    tick();
    chk("late_y_next", 32'(y_hi), 32'hB);
    tick();
    chk("late_done", 32'(valid_hi), 0);

    // reset mid-operation with everything pending
    ready = 1'b0; req = 16'hFFFF;
    tick(); req = '0;
    chk("full_cnt", 32'(cnt_hi), 16);
    tick();
    chk("full_valid", 32'(valid_hi), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pend", 32'(pend_hi), 0);
    chk("async_valid", 32'(valid_hi), 0);
    chk("async_y", 32'(y_lo), 0);
    chk("async_cnt", 32'(cnt_lo), 0);
    tick();
    #2 rst_n = 1'b1; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_idle", 32'(valid_hi | valid_lo), 0);
    end

    chk("hi_queue_drained", 32'(q_hi.size()), 0);
    chk("lo_queue_drained", 32'(q_lo.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/enc16x4_irq.md
ENC16X4_IRQ -- requirements
Module: enc16x4_irq

Interface
REQ-001 SHALL provide parameter HI_FIRST, default 1: 1 = highest set index wins, 0 = lowest set index wins.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port req  input  16  request lines; level sampled every clk edge.
REQ-005 SHALL provide port mask  input  16  1 = line excluded from encoding (still latched as pending).
REQ-006 SHALL provide port ready  input  1  consumer accepts current code when high with valid.
REQ-007 SHALL provide port valid  output  1  Y holds a code awaiting acceptance.
REQ-008 SHALL provide port Y  output  4  encoded index of the selected pending request.
REQ-009 SHALL provide port pend  output  16  sticky pending-request register.
REQ-010 SHALL provide port pend_cnt  output  5  popcount of pend, 0..16.

Function
REQ-011 SHALL define handshake fire = valid & ready, ack_mask = fire ? onehot(Y) : 16'h0000.
REQ-012 SHALL update every edge pend <= (pend & ~ack_mask) | req; a req bit high in the same cycle its code is accepted leaves that bit set (re-arm wins).
REQ-013 SHALL form cand = pend & ~ack_mask & ~mask (combinational, registered pend only; req not bypassed).
REQ-014 SHALL load the output stage when load = ~valid | ready; otherwise valid and Y hold unchanged (Y stable while valid & ~ready).
REQ-015 SHALL on load set valid <= (cand != 0), Y <= encode(cand) per HI_FIRST; when cand == 0, valid <= 0 and Y holds its previous value.
REQ-016 SHALL have latency of exactly 2 edges from req first sampled high (edge k sets pend) to valid high (edge k+1), given output stage loadable.
REQ-017 SHALL sustain one accepted code per cycle when ready held high and cand stays nonzero (back-to-back, no bubble).
REQ-018 SHALL not change Y of an outstanding code if a higher-priority request arrives; the new request is taken at the next load.
REQ-019 SHALL leave the code in Y valid if its mask bit rises while valid & ~ready; mask affects only future loads.
REQ-020 SHALL compute pend_cnt combinationally from the pend register (0 when empty, 16 when all set, no wrap).
REQ-021 SHALL never present valid with Y indexing a bit not set in pend at load time.

Reset
REQ-022 SHALL on rst_n low, immediately and independent of clk, force pend = 16'h0000, valid = 0, Y = 4'h0, pend_cnt = 0.
REQ-023 SHALL discard any outstanding code and all pending bits on reset mid-operation; first sampling of req occurs on the first rising clk edge after rst_n deasserts.

Verification
REQ-024 SHALL cover single request: HI_FIRST=1, ready=1, req=16'h0020 for one cycle -> pend=16'h0020 after edge 1, valid=1 Y=4'h5 after edge 2, pend=0 and valid=0 after edge 3.
REQ-025 SHALL cover priority/backpressure: req=16'h8101 one cycle, ready=0 -> valid=1 Y=4'hF held; ready=1 then gives Y sequence F, 8, 0 on consecutive cycles, pend_cnt 3->2->1->0.
REQ-026 SHALL cover HI_FIRST=0 with same stimulus -> Y sequence 0, 8, F.
REQ-027 SHALL cover mask: pend=16'h0003, mask=16'h0001 -> only Y=1 issued, pend=16'h0001 retained; clear mask -> Y=0 issued next load.
REQ-028 SHALL cover re-arm: req bit 4 held high through acceptance of Y=4 -> pend[4] stays 1, Y=4 reissued the following cycle.
REQ-029 SHALL cover reset mid-operation: rst_n low between clk edges with valid=1, pend=16'hFFFF -> outputs zero asynchronously before next edge; no code reissued after release until req re-asserted.
